fpu_divider_scheduler: RTL

FPU_DIVIDER_SCHEDULER -- requirements
Module: fpu_divider_scheduler

---
 rtl/fpu_divider_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_divider_scheduler.sv
// Two-requester scheduler in front of a shared float32 divider, with a result buffer and a watchdog.
// Optional macro FPU_DIV_FLUSH_EN adds flush_i and a DRAIN state that discards an in-flight result.
module fpu_divider_scheduler #(
    parameter int TAG_W   = 3,
    parameter int MAX_LAT = 63
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [63:0]        req_dividend_i,
    input  logic [63:0]        req_divisor_i,
    input  logic [2*TAG_W-1:0] req_tag_i,
    output logic               div_valid_o,
    output logic [31:0]        div_dividend_o,
    output logic [31:0]        div_divisor_o,
    input  logic               div_valid_i,
    input  logic [31:0]        div_result_i,
    input  logic [5:0]         div_flags_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_owner_o,
    output logic [TAG_W-1:0]   res_tag_o,
    output logic [31:0]        res_result_o,
    output logic [5:0]         res_flags_o,
    output logic               timeout_o,
    output logic               busy_o
`ifdef FPU_DIV_FLUSH_EN
    ,
    input  logic               flush_i
`endif
);

    localparam int WD_W = $clog2(MAX_LAT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_LAT - 1);

`ifdef FPU_DIV_FLUSH_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       dvd_q, dvd_d;
    logic [31:0]       dvs_q, dvs_d;
    logic [31:0]       res_q, res_d;
    logic [5:0]        flags_q, flags_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        grant_s;
    logic              sel_s;
    logic              flush_s;

`ifdef FPU_DIV_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // State, operand latch, result buffer and watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            tag_q     <= '0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            res_q     <= 32'd0;
            flags_q   <= 6'd0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tag_q     <= tag_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: grant arbitration, issue, wait with watchdog, hold until consumed.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tag_d     = tag_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        flags_d   = flags_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        grant_s   = 2'b00;
        sel_s     = (req_valid_i == 2'b11) ? ptr_q : req_valid_i[1];
        case (state_q)
            S_IDLE: begin
                if (!flush_s && (req_valid_i != 2'b00)) begin
                    grant_s = sel_s ? 2'b10 : 2'b01;
                    owner_d = sel_s;
                    ptr_d   = ~sel_s;
                    tag_d   = sel_s ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
                    dvd_d   = sel_s ? req_dividend_i[63:32] : req_dividend_i[31:0];
                    dvs_d   = sel_s ? req_divisor_i[63:32] : req_divisor_i[31:0];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = flush_s ? S_IDLE : S_WAIT;
`ifdef FPU_DIV_FLUSH_EN
                if (flush_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_WAIT: begin
`ifdef FPU_DIV_FLUSH_EN
                if (flush_s) begin
                    state_d = div_valid_i ? S_IDLE : S_DRAIN;
                end else
`endif
                // A result arriving on the expiry cycle beats the watchdog.
                if (div_valid_i) begin
                    res_d   = div_result_i;
                    flags_d = div_flags_i;
                    state_d = S_HOLD;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready_i || flush_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
`ifdef FPU_DIV_FLUSH_EN
            S_DRAIN: begin
                if (div_valid_i) begin
                    state_d = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The grant is combinational on the request; it is masked while reset is held.
    assign req_ready_o    = rst_i ? 2'b00 : grant_s;
    assign div_valid_o    = (state_q == S_ISSUE);
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign res_valid_o    = (state_q == S_HOLD);
    assign res_owner_o    = owner_q;
    assign res_tag_o      = tag_q;
    assign res_result_o   = res_q;
    assign res_flags_o    = flags_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
